// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding and default limits.
package dmem_arb_pkg;

  // Each state names the owner of the previous cycle.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CPU      = 2'd1,
    S_DMA      = 2'd2,
    S_DMA_LOCK = 2'd3
  } arb_state_t;

  localparam int unsigned DEF_MAX_STREAK = 4;
  localparam int unsigned DEF_MAX_BURST  = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] LIMIT = W'(MAX);

  logic [W-1:0] r_cnt;

  // Count up to LIMIT and hold there until cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU load/store path
// and a DMA/program-loader requester, with starvation bounds in both directions.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MAX_STREAK = DEF_MAX_STREAK,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cpu_re,
  input  logic             i_cpu_we,
  input  logic [WIDTH-1:0] i_cpu_addr,
  input  logic [WIDTH-1:0] i_cpu_wdata,
  output logic             o_cpu_gnt,
  output logic             o_cpu_stall,
  output logic [WIDTH-1:0] o_cpu_rdata,
  input  logic             i_dma_req,
  input  logic             i_dma_we,
  input  logic             i_dma_lock,
  input  logic [WIDTH-1:0] i_dma_addr,
  input  logic [WIDTH-1:0] i_dma_wdata,
  output logic             o_dma_gnt,
  output logic [WIDTH-1:0] o_dma_rdata,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  output logic             o_mem_we,
  output logic             o_mem_re,
  input  logic [WIDTH-1:0] i_mem_rdata
);

  localparam logic [CNT_W-1:0] STREAK_LIM = CNT_W'(MAX_STREAK);
  localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(MAX_BURST);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             w_cpu_req;
  logic             w_dma_win;
  logic             w_cpu_win;
  logic             w_lock_exit;
  logic             w_streak_inc;
  logic             w_streak_clr;
  logic             w_burst_inc;
  logic             w_burst_clr;
  logic [CNT_W-1:0] w_streak;
  logic [CNT_W-1:0] w_burst;

  assign w_cpu_req = i_cpu_re | i_cpu_we;

  // Grant decision: DMA wins when the CPU is idle, the CPU streak is exhausted,
  // or a lock is running with burst budget left; otherwise the CPU wins.
  always_comb begin
    w_dma_win = 1'b0;
    w_cpu_win = 1'b0;
    if (i_dma_req && (!w_cpu_req || (w_streak == STREAK_LIM) ||
                      ((r_state == S_DMA_LOCK) && (w_burst < BURST_LIM)))) begin
      w_dma_win = 1'b1;
    end else if (w_cpu_req) begin
      w_cpu_win = 1'b1;
    end
  end

  // Next-state logic; lock exit is sampled at the edge and takes precedence.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_lock_exit = (r_state == S_DMA_LOCK) && (!i_dma_req || !i_dma_lock);
    if (w_lock_exit) begin
      w_state_nxt = S_IDLE;
    end else if (w_dma_win) begin
      w_state_nxt = i_dma_lock ? S_DMA_LOCK : S_DMA;
    end else if (w_cpu_win) begin
      // A forced CPU slot inside a lock keeps the lock alive.
      w_state_nxt = (r_state == S_DMA_LOCK) ? S_DMA_LOCK : S_CPU;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter control, derived from ungated grants so reset only gates the outputs.
  always_comb begin
    w_streak_inc = w_cpu_win & i_dma_req;
    w_streak_clr = w_dma_win | ~i_dma_req;
    w_burst_inc  = w_dma_win & ((r_state == S_DMA_LOCK) | i_dma_lock);
    w_burst_clr  = w_cpu_win | (w_state_nxt != S_DMA_LOCK);
  end

  sat_counter #(
    .W   (CNT_W),
    .MAX (MAX_STREAK)
  ) u_streak (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_streak_clr),
    .i_inc   (w_streak_inc),
    .o_cnt   (w_streak)
  );

  sat_counter #(
    .W   (CNT_W),
    .MAX (MAX_BURST)
  ) u_burst (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_burst_clr),
    .i_inc   (w_burst_inc),
    .o_cnt   (w_burst)
  );

  // Memory port mux and grant outputs; everything is held inactive during reset.
  always_comb begin
    o_cpu_gnt   = w_cpu_win & i_rst_n;
    o_dma_gnt   = w_dma_win & i_rst_n;
    o_mem_addr  = i_cpu_addr;
    o_mem_wdata = i_cpu_wdata;
    o_mem_we    = 1'b0;
    o_mem_re    = 1'b0;
    if (o_dma_gnt) begin
      o_mem_addr  = i_dma_addr;
      o_mem_wdata = i_dma_wdata;
      o_mem_we    = i_dma_we;
      o_mem_re    = ~i_dma_we;
    end else if (o_cpu_gnt) begin
      o_mem_we    = i_cpu_we;
      o_mem_re    = i_cpu_re & ~i_cpu_we;
    end
    o_cpu_stall = w_cpu_req & ~o_cpu_gnt & i_rst_n;
  end

  assign o_cpu_rdata = i_mem_rdata;
  assign o_dma_rdata = i_mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we, dma_lock;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  logic [31:0] mem  [0:255];
  logic [31:0] snap [0:255];

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(
    .WIDTH      (32),
    .MAX_STREAK (4),
    .MAX_BURST  (8),
    .CNT_W      (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cpu_re    (cpu_re),
    .i_cpu_we    (cpu_we),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_gnt   (cpu_gnt),
    .o_cpu_stall (cpu_stall),
    .o_cpu_rdata (cpu_rdata),
    .i_dma_req   (dma_req),
    .i_dma_we    (dma_we),
    .i_dma_lock  (dma_lock),
    .i_dma_addr  (dma_addr),
    .i_dma_wdata (dma_wdata),
    .o_dma_gnt   (dma_gnt),
    .o_dma_rdata (dma_rdata),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_we    (mem_we),
    .o_mem_re    (mem_re),
    .i_mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  initial begin
    int diffs;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    idle_inputs();
    rst_n = 0;

    // Reset state
    #1;
    chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    chk("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(S_IDLE));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // CPU-only store then load
    @(negedge clk);
    cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #1;
    chk("st_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("st_stall", {31'd0, cpu_stall}, 32'd0);
    chk("st_we", {31'd0, mem_we}, 32'd1);
    @(negedge clk);
    cpu_we = 0; cpu_re = 1;
    #1;
    chk("ld_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("ld_stall", {31'd0, cpu_stall}, 32'd0);
    chk("ld_re", {31'd0, mem_re}, 32'd1);
    chk("ld_data", cpu_rdata, 32'hDEADBEEF);

    // re and we together behave as a store
    @(negedge clk);
    cpu_re = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
    #1;
    chk("rw_we", {31'd0, mem_we}, 32'd1);
    chk("rw_re", {31'd0, mem_re}, 32'd0);
    @(negedge clk);
    cpu_we = 0;
    #1;
    chk("rw_data", cpu_rdata, 32'h12345678);

    // One idle cycle returns the FSM to S_IDLE
    @(negedge clk);
    idle_inputs();
    #1;
    chk("gap_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd0);

    // Continuous CPU+DMA, no lock: CPU x4, DMA x1 repeating
    @(negedge clk);
    chk("both_start_state", 32'(dut.r_state), 32'(S_IDLE));
    cpu_re = 1; cpu_addr = 32'h10;
    dma_req = 1; dma_we = 0; dma_addr = 32'h40;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("pat_cpu_%0d", i), {31'd0, cpu_gnt},   ((i % 5) == 4) ? 32'd0 : 32'd1);
      chk($sformatf("pat_dma_%0d", i), {31'd0, dma_gnt},   ((i % 5) == 4) ? 32'd1 : 32'd0);
      chk($sformatf("pat_stl_%0d", i), {31'd0, cpu_stall}, ((i % 5) == 4) ? 32'd1 : 32'd0);
    end

    // Locked DMA write burst of 12 with CPU requesting: DMA x8, CPU x1, DMA x4
    dma_lock = 1; dma_we = 1;
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      dma_addr = 32'h80 + 32'(j) * 4; dma_wdata = 32'(j) + 32'h100;
      #1;
      chk($sformatf("lk_dma_%0d", j), {31'd0, dma_gnt}, (j == 8) ? 32'd0 : 32'd1);
      chk($sformatf("lk_cpu_%0d", j), {31'd0, cpu_gnt}, (j == 8) ? 32'd1 : 32'd0);
      if (j == 8) begin
        chk("lk_forced_state", 32'(dut.r_state), 32'(S_DMA_LOCK));
        chk("lk_forced_burst", 32'(dut.w_burst), 32'd8);
      end
    end
    // Lock and request drop together
    @(negedge clk);
    dma_req = 0; dma_lock = 0; dma_we = 0;
    #1;
    chk("lk_exit_cpu", {31'd0, cpu_gnt}, 32'd1);
    @(negedge clk);
    chk("lk_exit_state",
        {31'd0, (dut.r_state == S_IDLE) || (dut.r_state == S_CPU)}, 32'd1);
    chk("lk_mem_j3", mem[(32'h80 >> 2) + 3], 32'h103);
    chk("lk_mem_j9", mem[(32'h80 >> 2) + 9], 32'h109);

    // Reset mid-burst on a DMA write cycle
    idle_inputs();
    dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 32'hC0; dma_wdata = 32'hAAAAAAAA;
    @(negedge clk);
    dma_addr = 32'hC4; dma_wdata = 32'h55555555;
    #1;
    chk("mid_we_pre", {31'd0, mem_we}, 32'd1);
    chk("mid_state_pre", 32'(dut.r_state), 32'(S_DMA_LOCK));
    #1;
    rst_n = 0;
    #1;
    chk("mid_we_rst", {31'd0, mem_we}, 32'd0);
    chk("mid_gnt_rst", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
    chk("mid_burst_rst", 32'(dut.w_burst), 32'd0);
    chk("mid_streak_rst", 32'(dut.w_streak), 32'd0);
    chk("mid_state_rst", 32'(dut.r_state), 32'(S_IDLE));
    @(negedge clk);
    chk("mid_mem_prev", mem[32'hC0 >> 2], 32'hAAAAAAAA);
    chk("mid_mem_drop", mem[32'hC4 >> 2], 32'd0);
    rst_n = 1;
    cpu_re = 1; cpu_addr = 32'h10;
    #1;
    chk("post_rst_cpu", {31'd0, cpu_gnt}, 32'd1);
    chk("post_rst_dma", {31'd0, dma_gnt}, 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_cpu2", {31'd0, cpu_gnt}, 32'd1);

    // Neither port requests for 10 cycles
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 256; i++) snap[i] = mem[i];
    #1;
    chk("idle_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
    chk("idle_en", {29'd0, mem_we, mem_re, cpu_stall}, 32'd0);
    repeat (10) @(negedge clk);
    chk("idle_state", 32'(dut.r_state), 32'(S_IDLE));
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) diffs++;
    chk("idle_mem", 32'(diffs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port data memory between the CPU datapath load/store path and a DMA/program-loader requester.
- Sits between the control logic's memory enables and the data memory. CPU accesses normally win.
- Two saturating counters bound starvation in both directions.
- Holds the PC via `o_cpu_stall` whenever the CPU is denied.

## Interface

- `WIDTH`, 32: data and address width.
- `MAX_STREAK`, 4: consecutive CPU grants allowed while DMA waits before DMA is forced in.
- `MAX_BURST`, 8: consecutive DMA grants allowed in a locked burst while the CPU waits before the CPU is forced in.
- `CNT_W`, 4: width of both counters; must hold `MAX_BURST`.
- `i_clk` input 1: clock, rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_cpu_re` input 1: CPU load request (Mem_Read).
- `i_cpu_we` input 1: CPU store request (Mem_Write).
- `i_cpu_addr` input WIDTH: CPU address (ALU result).
- `i_cpu_wdata` input WIDTH: CPU store data.
- `o_cpu_gnt` output 1: CPU access performed this cycle.
- `o_cpu_stall` output 1: CPU requesting and not granted; freezes the PC and register write.
- `o_cpu_rdata` output WIDTH: read data.
- `i_dma_req` input 1: DMA access request.
- `i_dma_we` input 1: DMA write (1) or read (0).
- `i_dma_lock` input 1: DMA requests a locked burst.
- `i_dma_addr` input WIDTH: DMA address.
- `i_dma_wdata` input WIDTH: DMA write data.
- `o_dma_gnt` output 1: DMA access performed this cycle.
- `o_dma_rdata` output WIDTH: read data.
- `o_mem_addr` output WIDTH: address to data memory.
- `o_mem_wdata` output WIDTH: write data to data memory.
- `o_mem_we` output 1: write enable to data memory.
- `o_mem_re` output 1: read enable to data memory.
- `i_mem_rdata` input WIDTH: combinational read data from data memory.

## Operation

**Requests**
- cpu_req = `i_cpu_re | i_cpu_we`.
- If both `i_cpu_re` and `i_cpu_we` are high, it is treated as a write; `o_mem_re` stays 0 in that case.
- dma_req = `i_dma_req`.

**States**
- Registered FSM states: `S_IDLE`, `S_CPU`, `S_DMA`, `S_DMA_LOCK`. Each names the owner of the previous cycle.
- Counters: `streak` counts CPU grants while DMA waits; `burst` counts DMA grants in a lock.

**Grant rule (combinational, evaluated every cycle)**
- DMA wins when dma_req is high and any of these holds:
  - cpu_req is 0;
  - `streak == MAX_STREAK`;
  - state is `S_DMA_LOCK` and `burst < MAX_BURST`.
- Otherwise the CPU wins if cpu_req is high. If neither requests, there is no grant.
- At most one of `o_cpu_gnt` / `o_dma_gnt` is high in any cycle.

**Datapath and outputs**
- `o_mem_*` are muxed from the granted port.
- With no grant: `o_mem_we = o_mem_re = 0`, and `o_mem_addr` / `o_mem_wdata` hold the CPU inputs.
- `o_cpu_rdata = o_dma_rdata = i_mem_rdata` unconditionally. Data is valid only in a cycle where that port's grant is high.
- `o_cpu_stall = cpu_req & ~o_cpu_gnt`.

**Counter updates (at clock edge)**
- `streak`:
  - +1, saturating at `MAX_STREAK`, on a CPU grant with dma_req high;
  - cleared on a DMA grant, or when dma_req is 0.
- `burst`:
  - +1, saturating at `MAX_BURST`, on a DMA grant in or entering `S_DMA_LOCK`;
  - cleared on a CPU grant, or on exit from the lock.

**FSM transitions**
- DMA grant with `i_dma_lock = 1` → `S_DMA_LOCK`.
- DMA grant with `i_dma_lock = 0` → `S_DMA`.
- CPU grant → `S_CPU`, except inside a lock: a forced CPU slot (`burst == MAX_BURST`) stays in `S_DMA_LOCK` with `burst` cleared.
- No grant → `S_IDLE`.
- `S_DMA_LOCK` exits to `S_IDLE` when `i_dma_req` or `i_dma_lock` is low.

## Timing

- Zero-latency arbitration: grant, mem enables and read data are combinational within the request cycle.
- Writes commit at the rising edge that ends the grant cycle.
- Requests are level-sensitive. A denied requester must hold its request, address and data stable until granted; there is no queue.
- Worst-case CPU wait is `MAX_BURST` cycles. Worst-case DMA wait is `MAX_STREAK` cycles.
- Reset, whether asserted at start-up or mid-operation:
  - state becomes `S_IDLE` and both counters clear immediately;
  - while `i_rst_n` is low, grants, `o_mem_we`, `o_mem_re` and `o_cpu_stall` are forced 0;
  - an in-flight write is dropped;
  - normal arbitration resumes in the first cycle after release.
- CPU request and lock exit on the same cycle: the lock-exit condition is sampled at the edge, and the grant rule uses the current state.

## Structure

- Shared package `dmem_arb_pkg` holds:
  - the state encoding (2 bits);
  - default values of `MAX_STREAK` and `MAX_BURST`.
- One sub-module is natural: `sat_counter`, with clear, increment and saturation limit. It is instantiated twice, for `streak` and `burst`.

## Test plan

- Only the CPU requests, store `addr = 0x10`, `wdata = 0xDEADBEEF`, then a load from `0x10`:
  - `o_cpu_gnt = 1` both cycles, stall 0;
  - the load returns `0xDEADBEEF`.
- CPU and DMA request continuously, no lock, `MAX_STREAK = 4`:
  - grant pattern CPU ×4, DMA ×1, repeating;
  - `o_cpu_stall = 1` exactly in the DMA cycles.
- Locked DMA burst of 12 with the CPU requesting throughout, `MAX_BURST = 8`:
  - DMA ×8, CPU ×1, DMA ×4;
  - then the lock drops and the FSM returns to `S_IDLE` or `S_CPU`.
- Both requests high in the same cycle with `S_IDLE` and `streak = 0`: CPU is granted, DMA waits one cycle.
- Reset asserted mid-burst, on a DMA write cycle:
  - `o_mem_we` drops immediately, the write is not committed, and the counters are 0;
  - after release, the CPU is granted first.
- Neither port requests:
  - all grants and enables are 0, state is `S_IDLE`;
  - no memory change over 10 cycles.
